// File: rtl/audio_pwm_player.sv
// Audio PWM player: streams packed samples out of a word-wide sample memory and
// plays them as PWM at a programmable sample rate with a shift-based volume.
module audio_pwm_player #(
  parameter int DATA_WIDTH = 8,
  parameter int WORD_WIDTH = 32,
  parameter int ADDR_WIDTH = 12,
  parameter int DIV_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  aud_en,
  input  logic                  start,
  input  logic                  loop_en,
  input  logic [ADDR_WIDTH-1:0] start_addr,
  input  logic [ADDR_WIDTH-1:0] end_addr,
  input  logic [DIV_WIDTH-1:0]  rate_div,
  input  logic [2:0]            volume,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [WORD_WIDTH-1:0] mem_data,
  output logic                  aud_pwm,
  output logic                  aud_sd,
  output logic                  busy,
  output logic                  done
);
  localparam int NSAMP = WORD_WIDTH / DATA_WIDTH;
  localparam int IDX_W = (NSAMP > 1) ? $clog2(NSAMP) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSAMP - 1);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_WAIT, S_PLAY} state_t;
  state_t state_q, state_d;

  logic [ADDR_WIDTH-1:0] mem_addr_q, start_q, end_q;
  logic                  loop_q;
  logic [DIV_WIDTH-1:0]  rate_q, div_q;
  logic [2:0]            vol_q;
  logic [WORD_WIDTH-1:0] word_buf_q;
  logic [IDX_W-1:0]      idx_q;
  logic                  tick_pend_q;
  logic [DATA_WIDTH-1:0] next_sample_q, pwm_cnt_q, compare_q;
  logic                  aud_pwm_q, done_q;

  logic                  start_go, tick, play_tick, last_tick, at_end, done_d;
  logic [DATA_WIDTH-1:0] cur_sample;

  assign start_go   = (state_q == S_IDLE) && start && aud_en;
  assign tick       = busy && (div_q == rate_q);
  assign play_tick  = (state_q == S_PLAY) && (tick || tick_pend_q);
  assign last_tick  = play_tick && (idx_q == LAST_IDX);
  assign at_end     = (mem_addr_q == end_q);
  assign done_d     = last_tick && at_end && !loop_q && aud_en;
  // Samples are unpacked from the least significant end of the word first.
  assign cur_sample = DATA_WIDTH'(word_buf_q >> (idx_q * DATA_WIDTH));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start && aud_en) state_d = S_FETCH;
      S_FETCH: state_d = S_WAIT;
      S_WAIT:  state_d = S_PLAY;
      S_PLAY:  if (last_tick) state_d = (at_end && !loop_q) ? S_IDLE : S_FETCH;
      default: state_d = S_IDLE;
    endcase
    if (state_q != S_IDLE && !aud_en) state_d = S_IDLE;
  end

  always_comb begin
    busy     = (state_q != S_IDLE);
    aud_sd   = busy;
    done     = done_q;
    aud_pwm  = aud_pwm_q;
    mem_addr = mem_addr_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_addr_q    <= '0;
      start_q       <= '0;
      end_q         <= '0;
      loop_q        <= 1'b0;
      rate_q        <= '0;
      vol_q         <= '0;
      div_q         <= '0;
      tick_pend_q   <= 1'b0;
      word_buf_q    <= '0;
      idx_q         <= '0;
      next_sample_q <= '0;
      done_q        <= 1'b0;
    end else begin
      done_q <= done_d;
      if (start_go) begin
        start_q       <= start_addr;
        end_q         <= end_addr;
        loop_q        <= loop_en;
        rate_q        <= rate_div;
        vol_q         <= volume;
        mem_addr_q    <= start_addr;
        div_q         <= '0;
        tick_pend_q   <= 1'b0;
        next_sample_q <= '0;
      end else if (busy) begin
        div_q <= tick ? '0 : div_q + 1'b1;
        // A tick landing while the next word is in flight is held for PLAY.
        if (state_q == S_PLAY) tick_pend_q <= 1'b0;
        else if (tick)         tick_pend_q <= 1'b1;
        if (state_q == S_WAIT) begin
          word_buf_q <= mem_data;
          idx_q      <= '0;
        end
        if (play_tick) begin
          next_sample_q <= cur_sample >> vol_q;
          idx_q         <= idx_q + 1'b1;
          if (last_tick && aud_en) begin
            if (!at_end)     mem_addr_q <= mem_addr_q + 1'b1;
            else if (loop_q) mem_addr_q <= start_q;
          end
        end
      end
    end
  end

  // Compare only reloads at the counter wrap so a PWM period is never torn.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pwm_cnt_q <= '0;
      compare_q <= '0;
      aud_pwm_q <= 1'b0;
    end else if (state_d == S_IDLE) begin
      pwm_cnt_q <= '0;
      compare_q <= '0;
      aud_pwm_q <= 1'b0;
    end else begin
      pwm_cnt_q <= busy ? pwm_cnt_q + 1'b1 : '0;
      if (busy && pwm_cnt_q == '1) compare_q <= next_sample_q;
      aud_pwm_q <= (pwm_cnt_q < compare_q);
    end
  end

endmodule

// File: doc/audio_pwm_player.md
AUDIO_PWM_PLAYER -- requirements
Module: audio_pwm_player

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- DATA_WIDTH, 8, sample width and PWM resolution.
- WORD_WIDTH, 32, memory word width; SHALL be an integer multiple of DATA_WIDTH.
- ADDR_WIDTH, 12, sample-memory address width.
- DIV_WIDTH, 16, sample-rate divider width.
REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk, in, 1, single clock.
- rst, in, 1, asynchronous active-high reset.
- aud_en, in, 1, level enable; low aborts playback.
- start, in, 1, one-cycle start pulse.
- loop_en, in, 1, restart at start_addr after end_addr.
- start_addr, in, ADDR_WIDTH, first word address.
- end_addr, in, ADDR_WIDTH, last word address, inclusive.
- rate_div, in, DIV_WIDTH, sample period minus 1, in clk cycles; legal range is at least 3.
- volume, in, 3, right-shift attenuation, 0 to 7.
- mem_addr, out, ADDR_WIDTH, registered sample-memory read address.
- mem_data, in, WORD_WIDTH, read data, valid exactly 1 cycle after mem_addr.
- aud_pwm, out, 1, PWM audio output.
- aud_sd, out, 1, amplifier enable; equals busy.
- busy, out, 1, high from FETCH entry until return to IDLE.
- done, out, 1, one-cycle pulse at the end of a non-looping play.

Function
REQ-003 The FSM SHALL have four states: IDLE, FETCH, WAIT and PLAY.
REQ-004 IDLE to FETCH transition:
- Occurs when start=1 and aud_en=1.
- start_addr, end_addr, loop_en, rate_div and volume SHALL be captured into internal registers.
- mem_addr SHALL be set to start_addr.
- While busy, changes on these inputs SHALL be ignored.
REQ-005 FETCH SHALL last exactly 1 cycle and then go to WAIT.
REQ-006 In WAIT, mem_data SHALL be latched into word_buf, sample_idx SHALL be set to 0, and the FSM SHALL go to PLAY.
REQ-007 Sample-rate divider:
- Resets to 0 on the IDLE to FETCH transition.
- Counts 0..rate_div while busy.
- Asserts a one-cycle tick at count==rate_div, then wraps to 0.
REQ-008 A tick occurring in FETCH or WAIT SHALL set tick_pend; tick_pend SHALL be consumed on the first PLAY cycle, so no tick is ever lost.
REQ-009 On each tick (or pending tick) in PLAY:
- Sample extraction: next_sample SHALL be word_buf[sample_idx*DATA_WIDTH +: DATA_WIDTH] logically right-shifted by volume (unsigned).
- sample_idx SHALL increment.
- Samples are unpacked LSB first.
REQ-010 When the tick consumes the last sample (sample_idx = WORD_WIDTH/DATA_WIDTH - 1):
- If mem_addr != end_addr: mem_addr SHALL increment modulo 2^ADDR_WIDTH, then go to FETCH.
- Else, if loop_en=1: mem_addr SHALL be set to start_addr, then go to FETCH.
- Else: go to IDLE with done=1 for that cycle.
REQ-011 Address wrap: if end_addr < start_addr, addresses SHALL wrap through 2^ADDR_WIDTH-1 to 0.
REQ-012 PWM counter:
- pwm_cnt is DATA_WIDTH bits and free-runs while busy, wrapping from all-ones to 0.
- The compare register SHALL load next_sample only on the cycle pwm_cnt wraps to 0, giving glitch-free update.
REQ-013 aud_pwm SHALL be registered and equal (pwm_cnt < compare) while busy, and 0 in IDLE.
- compare=0 gives constant 0.
- compare=2^DATA_WIDTH-1 gives high for all but 1 cycle per period.
REQ-014 aud_en low in any non-IDLE state SHALL force IDLE on the next cycle:
- aud_pwm, busy and aud_sd go to 0.
- done is not asserted.
- compare and pwm_cnt are cleared.
REQ-015 start while busy SHALL be ignored; start and aud_en falling in the same cycle SHALL resolve as abort.
REQ-016 done SHALL never assert in loop mode; clearing loop_en mid-play SHALL have no effect until the next start.

Reset
REQ-017 Asynchronous rst=1 SHALL immediately force:
- FSM to IDLE.
- mem_addr, word_buf, sample_idx, divider, tick_pend, pwm_cnt and compare to 0.
- aud_pwm, aud_sd, busy and done to 0.
REQ-018 Reset deasserted mid-play SHALL NOT resume playback; a new start is required.

Verification
REQ-019 Basic play, defaults:
- Stimulus: start_addr=0x010, end_addr=0x011, rate_div=299, volume=0, loop_en=0, memory words 0x40302010 and 0x80706050.
- Required response: mem_addr sequence 0x010, 0x011; samples 0x10, 0x20, ..., 0x80 in order; done pulses once, 1 cycle after the 8th tick consumes 0x80; busy returns to 0.
REQ-020 Duty check: with a constant sample of 0x40 and volume=0, aud_pwm SHALL be high for exactly 64 of every 256 cycles; with volume=2 it SHALL be high for 16.
REQ-021 Loop wrap:
- Stimulus: start_addr=0xFFF, end_addr=0x001, loop_en=1.
- Required response: mem_addr 0xFFF, 0x000, 0x001, 0xFFF, ...; done never asserts.
REQ-022 Abort: aud_en dropped during WAIT SHALL put the FSM in IDLE next cycle, with aud_pwm=0, busy=0 and no done; a following start replays from start_addr.
REQ-023 Async reset:
- Stimulus: rst pulsed mid-PLAY, not aligned to clk.
- Required response: all outputs 0 before the next clk edge; no activity until a new start.
REQ-024 Minimum rate: with rate_div=3, every tick crossing a FETCH/WAIT SHALL still produce a sample (tick_pend path), and the count of samples SHALL equal the count of ticks.
